// File: rtl/pwm_dt_pkg.sv
// Shared types and register layout for the PWM dead-time insertion stage.
package pwm_dt_pkg;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_LS_ON   = 3'd1,
      ST_DT_RISE = 3'd2,
      ST_HS_ON   = 3'd3,
      ST_DT_FALL = 3'd4
   } dt_state_e;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_DT     = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;

   localparam int unsigned CTRL_HS_POL_LSB = 8;
   localparam int unsigned CTRL_LS_POL_LSB = 16;
   localparam int unsigned CTRL_FAULT_EN   = 24;
   localparam int unsigned CTRL_FAULT_IEN  = 25;
   localparam int unsigned CTRL_GLITCH_IEN = 26;

   localparam int unsigned DT_FALL_LSB = 8;

   localparam int unsigned STS_FAULT      = 0;
   localparam int unsigned STS_GLITCH_LSB = 8;
   localparam int unsigned STS_FLT_LVL    = 16;

endpackage

// File: rtl/pwm_dt_chan.sv
// One complementary gate pair: break-before-make FSM, dead-time counter and
// output flops registered from the next state.
module pwm_dt_chan
   import pwm_dt_pkg::*;
#(
   parameter int unsigned DT_W = 8
) (
   input  logic            mclk,
   input  logic            h_reset_n,
   input  logic            en,
   input  logic            blk,
   input  logic            in_q,
   input  logic            hs_pol,
   input  logic            ls_pol,
   input  logic [DT_W-1:0] dt_rise,
   input  logic [DT_W-1:0] dt_fall,
   output logic            hs_drv,
   output logic            ls_drv,
   output logic            glitch
);

   dt_state_e       state, nxt;
   logic [DT_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         state  <= ST_OFF;
         cnt    <= '0;
         hs_drv <= 1'b0;
         ls_drv <= 1'b0;
      end else begin
         state  <= nxt;
         cnt    <= cnt_nxt;
         hs_drv <= (nxt == ST_HS_ON) ^ hs_pol;
         ls_drv <= (nxt == ST_LS_ON) ^ ls_pol;
      end
   end

   // The dead-time values are only sampled on DT-state entry, so register
   // updates never disturb a count already running.
   always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      glitch  = 1'b0;
      if (!en || blk) begin
         nxt = ST_OFF;
      end else begin
         case (state)
            ST_OFF: begin
               nxt     = ST_DT_FALL;
               cnt_nxt = dt_fall;
            end
            ST_LS_ON: begin
               if (in_q) begin
                  nxt     = ST_DT_RISE;
                  cnt_nxt = dt_rise;
               end
            end
            ST_DT_RISE: begin
               if (!in_q) begin
                  nxt    = ST_LS_ON;
                  glitch = 1'b1;
               end else if (cnt != '0) begin
                  cnt_nxt = cnt - DT_W'(1);
               end else begin
                  nxt = ST_HS_ON;
               end
            end
            ST_HS_ON: begin
               if (!in_q) begin
                  nxt     = ST_DT_FALL;
                  cnt_nxt = dt_fall;
               end
            end
            ST_DT_FALL: begin
               if (in_q) begin
                  nxt    = ST_HS_ON;
                  glitch = 1'b1;
               end else if (cnt != '0) begin
                  cnt_nxt = cnt - DT_W'(1);
               end else begin
                  nxt = ST_LS_ON;
               end
            end
            default: nxt = ST_OFF;
         endcase
      end
   end

endmodule

// File: rtl/pwm_deadtime.sv
// Dead-time insertion stage: register slave, fault synchronizer, interrupt
// and NCH complementary channel pairs.
module pwm_deadtime
   import pwm_dt_pkg::*;
#(
   parameter int unsigned NCH  = 3,
   parameter int unsigned DT_W = 8
) (
   input  logic           mclk,
   input  logic           h_reset_n,
   input  logic           reg_cs,
   input  logic           reg_wr,
   input  logic [1:0]     reg_addr,
   input  logic [31:0]    reg_wdata,
   input  logic [3:0]     reg_be,
   output logic [31:0]    reg_rdata,
   output logic           reg_ack,
   input  logic [NCH-1:0] pwm_wfm_i,
   input  logic           fault_i,
   output logic [NCH-1:0] pwm_hs_o,
   output logic [NCH-1:0] pwm_ls_o,
   output logic           dt_intr
);

   localparam logic [31:0] CH_ONES   = 32'((64'd1 << NCH) - 64'd1);
   localparam logic [31:0] CTRL_MASK = CH_ONES | (CH_ONES << CTRL_HS_POL_LSB)
                                     | (CH_ONES << CTRL_LS_POL_LSB)
                                     | (32'd7 << CTRL_FAULT_EN);

   logic [31:0]     ctrl_q, ctrl_d;
   logic [DT_W-1:0] dt_rise_q, dt_fall_q;
   logic            fault_sts;
   logic [NCH-1:0]  glitch_sts, glitch_set, w1c_glitch;
   logic            flt_meta, flt_s;
   logic [NCH-1:0]  in_q;
   logic            access, wr_en, w1c_fault, fault_set;
   logic [31:0]     be_mask, sts_word, dt_word, rd_mux;

   assign access    = reg_cs & ~reg_ack;
   assign wr_en     = access & reg_wr;
   assign be_mask   = {{8{reg_be[3]}}, {8{reg_be[2]}}, {8{reg_be[1]}}, {8{reg_be[0]}}};
   assign fault_set = flt_s & ctrl_q[CTRL_FAULT_EN];

   always_comb begin
      ctrl_d     = ctrl_q;
      w1c_fault  = 1'b0;
      w1c_glitch = '0;
      if (wr_en && reg_addr == ADDR_CTRL)
         ctrl_d = (ctrl_q & ~(be_mask & CTRL_MASK)) | (reg_wdata & be_mask & CTRL_MASK);
      if (wr_en && reg_addr == ADDR_STATUS) begin
         w1c_fault = reg_be[0] & reg_wdata[STS_FAULT];
         if (reg_be[1])
            w1c_glitch = reg_wdata[STS_GLITCH_LSB +: NCH];
      end
   end

   always_comb begin
      sts_word                          = '0;
      sts_word[STS_FAULT]               = fault_sts;
      sts_word[STS_GLITCH_LSB +: NCH]   = glitch_sts;
      sts_word[STS_FLT_LVL]             = flt_s;
      dt_word                           = '0;
      dt_word[DT_W-1:0]                 = dt_rise_q;
      dt_word[DT_FALL_LSB +: DT_W]      = dt_fall_q;
      case (reg_addr)
         ADDR_CTRL:   rd_mux = ctrl_q;
         ADDR_DT:     rd_mux = dt_word;
         ADDR_STATUS: rd_mux = sts_word;
         default:     rd_mux = '0;
      endcase
   end

   // Sticky status: a set event in the same cycle as its W1C wins.
   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         reg_ack    <= 1'b0;
         reg_rdata  <= '0;
         ctrl_q     <= '0;
         dt_rise_q  <= '0;
         dt_fall_q  <= '0;
         fault_sts  <= 1'b0;
         glitch_sts <= '0;
         flt_meta   <= 1'b0;
         flt_s      <= 1'b0;
         in_q       <= '0;
      end else begin
         reg_ack    <= access;
         reg_rdata  <= (access && !reg_wr) ? rd_mux : '0;
         ctrl_q     <= ctrl_d;
         if (wr_en && reg_addr == ADDR_DT && reg_be[0])
            dt_rise_q <= reg_wdata[DT_W-1:0];
         if (wr_en && reg_addr == ADDR_DT && reg_be[1])
            dt_fall_q <= reg_wdata[DT_FALL_LSB +: DT_W];
         fault_sts  <= fault_set | (fault_sts & ~w1c_fault);
         glitch_sts <= glitch_set | (glitch_sts & ~w1c_glitch);
         flt_meta   <= fault_i;
         flt_s      <= flt_meta;
         in_q       <= pwm_wfm_i;
      end
   end

   assign dt_intr = (fault_sts & ctrl_q[CTRL_FAULT_IEN])
                  | ((|glitch_sts) & ctrl_q[CTRL_GLITCH_IEN]);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      pwm_dt_chan #(.DT_W(DT_W)) u_chan (
         .mclk      (mclk),
         .h_reset_n (h_reset_n),
         .en        (ctrl_q[i]),
         .blk       (fault_sts),
         .in_q      (in_q[i]),
         .hs_pol    (ctrl_q[CTRL_HS_POL_LSB + i]),
         .ls_pol    (ctrl_q[CTRL_LS_POL_LSB + i]),
         .dt_rise   (dt_rise_q),
         .dt_fall   (dt_fall_q),
         .hs_drv    (pwm_hs_o[i]),
         .ls_drv    (pwm_ls_o[i]),
         .glitch    (glitch_set[i])
      );
   end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Randomized and directed bench for pwm_deadtime against a timestamp-based
// reference model of the break-before-make behaviour.
module tb_pwm_deadtime;

   localparam int NCH  = 3;
   localparam int DT_W = 8;
   localparam logic [31:0] CTRL_BITS = 32'h0707_0707;
   localparam logic [31:0] DT_BITS   = 32'h0000_FFFF;

   logic           mclk = 1'b0;
   logic           h_reset_n = 1'b0;
   logic           reg_cs = 1'b0;
   logic           reg_wr = 1'b0;
   logic [1:0]     reg_addr = '0;
   logic [31:0]    reg_wdata = '0;
   logic [3:0]     reg_be = '0;
   logic [31:0]    reg_rdata;
   logic           reg_ack;
   logic [NCH-1:0] pwm_wfm_i = '0;
   logic           fault_i = 1'b0;
   logic [NCH-1:0] pwm_hs_o, pwm_ls_o;
   logic           dt_intr;

   pwm_deadtime #(.NCH(NCH), .DT_W(DT_W)) dut (
      .mclk      (mclk),
      .h_reset_n (h_reset_n),
      .reg_cs    (reg_cs),
      .reg_wr    (reg_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_be    (reg_be),
      .reg_rdata (reg_rdata),
      .reg_ack   (reg_ack),
      .pwm_wfm_i (pwm_wfm_i),
      .fault_i   (fault_i),
      .pwm_hs_o  (pwm_hs_o),
      .pwm_ls_o  (pwm_ls_o),
      .dt_intr   (dt_intr)
   );

   always #5 mclk = ~mclk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", tag, act, exp, cyc);
      end
   endtask

   // Reference model: each pair either idles, owns a settled side, or waits
   // for an absolute edge number at which the opposite side may take over.
   typedef enum int {IDLE, LOW_SET, HIGH_SET, HIGH_PEND, LOW_PEND} side_e;
   side_e          m_side [NCH];
   int             m_due  [NCH];
   logic [31:0]    m_ctrl, m_dtw, m_rdata;
   logic           m_sync1, m_flt, m_fsts, m_ack;
   logic [NCH-1:0] m_gsts, m_inq, m_hs, m_ls, m_hp, m_lp;

   function automatic void model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_side[c] = IDLE;
         m_due[c]  = 0;
      end
      m_ctrl = '0; m_dtw = '0; m_rdata = '0;
      m_sync1 = 1'b0; m_flt = 1'b0; m_fsts = 1'b0; m_ack = 1'b0;
      m_gsts = '0; m_inq = '0; m_hs = '0; m_ls = '0; m_hp = '0; m_lp = '0;
   endfunction

   function automatic void model_edge();
      logic [NCH-1:0] en   = m_ctrl[NCH-1:0];
      int             dtr  = int'(m_dtw[7:0]);
      int             dtf  = int'(m_dtw[15:8]);
      logic           fe   = m_ctrl[24];
      logic [NCH-1:0] gset = '0;
      logic [NCH-1:0] wg   = '0;
      logic           wf   = 1'b0;
      logic [31:0]    sts  = '0;
      logic [31:0]    wm;
      m_hp = m_ctrl[8 +: NCH];
      m_lp = m_ctrl[16 +: NCH];
      for (int c = 0; c < NCH; c++) begin
         if (!en[c] || m_fsts) begin
            m_side[c] = IDLE;
         end else begin
            case (m_side[c])
               IDLE: begin m_side[c] = LOW_PEND; m_due[c] = cyc + dtf + 1; end
               LOW_SET: if (m_inq[c]) begin m_side[c] = HIGH_PEND; m_due[c] = cyc + dtr + 1; end
               HIGH_SET: if (!m_inq[c]) begin m_side[c] = LOW_PEND; m_due[c] = cyc + dtf + 1; end
               HIGH_PEND:
                  if (!m_inq[c]) begin m_side[c] = LOW_SET; gset[c] = 1'b1; end
                  else if (cyc >= m_due[c]) m_side[c] = HIGH_SET;
               LOW_PEND:
                  if (m_inq[c]) begin m_side[c] = HIGH_SET; gset[c] = 1'b1; end
                  else if (cyc >= m_due[c]) m_side[c] = LOW_SET;
               default: m_side[c] = IDLE;
            endcase
         end
         m_hs[c] = (m_side[c] == HIGH_SET) ^ m_hp[c];
         m_ls[c] = (m_side[c] == LOW_SET) ^ m_lp[c];
      end
      sts[0] = m_fsts;
      sts[8 +: NCH] = m_gsts;
      sts[16] = m_flt;
      if (reg_cs && !m_ack) begin
         m_ack = 1'b1;
         m_rdata = '0;
         wm = {{8{reg_be[3]}}, {8{reg_be[2]}}, {8{reg_be[1]}}, {8{reg_be[0]}}};
         if (reg_wr) begin
            case (reg_addr)
               2'd0: m_ctrl = (m_ctrl & ~(wm & CTRL_BITS)) | (reg_wdata & wm & CTRL_BITS);
               2'd1: m_dtw  = (m_dtw & ~(wm & DT_BITS)) | (reg_wdata & wm & DT_BITS);
               2'd2: begin
                  wf = reg_be[0] & reg_wdata[0];
                  if (reg_be[1]) wg = reg_wdata[8 +: NCH];
               end
               default: ;
            endcase
         end else begin
            case (reg_addr)
               2'd0: m_rdata = m_ctrl;
               2'd1: m_rdata = m_dtw;
               2'd2: m_rdata = sts;
               default: m_rdata = '0;
            endcase
         end
      end else begin
         m_ack = 1'b0;
         m_rdata = '0;
      end
      m_fsts  = (m_flt & fe) | (m_fsts & ~wf);
      m_gsts  = gset | (m_gsts & ~wg);
      m_flt   = m_sync1;
      m_sync1 = fault_i;
      m_inq   = pwm_wfm_i;
   endfunction

   task automatic tick();
      logic exp_intr;
      model_edge();
      @(posedge mclk);
      #1;
      cyc++;
      exp_intr = (m_fsts & m_ctrl[25]) | ((|m_gsts) & m_ctrl[26]);
      chk("hs", 32'(pwm_hs_o), 32'(m_hs));
      chk("ls", 32'(pwm_ls_o), 32'(m_ls));
      chk("ack", 32'(reg_ack), 32'(m_ack));
      chk("rdata", reg_rdata, m_rdata);
      chk("intr", 32'(dt_intr), 32'(exp_intr));
      chk("overlap", 32'((pwm_hs_o ^ m_hp) & (pwm_ls_o ^ m_lp)), 32'd0);
   endtask

   task automatic reg_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d; reg_be = be;
      tick();
      reg_cs = 1'b0; reg_wr = 1'b0; reg_be = '0;
      tick();
   endtask

   task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
      reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = a;
      tick();
      d = reg_rdata;
      reg_cs = 1'b0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation time limit exceeded");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      int c0, t_a, t_b;
      logic seen;
      model_reset();
      #2;
      chk("rst_hs", 32'(pwm_hs_o), 32'd0);
      chk("rst_ls", 32'(pwm_ls_o), 32'd0);
      chk("rst_ack", 32'(reg_ack), 32'd0);
      chk("rst_rdata", reg_rdata, 32'd0);
      chk("rst_intr", 32'(dt_intr), 32'd0);
      #1 h_reset_n = 1'b1;
      repeat (2) tick();

      // register handshake
      reg_write(2'd1, 32'h0000_0503, 4'b0001);
      reg_read(2'd1, d);
      chk("dt_be", d, 32'h0000_0003);
      reg_write(2'd3, 32'hFFFF_FFFF, 4'hF);
      reg_read(2'd3, d);
      chk("addr3", d, 32'd0);
      reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = 2'd1;
      tick();
      chk("ack_hi", 32'(reg_ack), 32'd1);
      tick();
      chk("ack_lo", 32'(reg_ack), 32'd0);
      reg_cs = 1'b0;
      tick();

      // normal dead time: rise 3, fall 5
      reg_write(2'd1, 32'h0000_0503, 4'b0011);
      reg_write(2'd0, 32'h0000_0001, 4'hF);
      repeat (10) tick();
      chk("idle_ls", 32'(pwm_ls_o[0]), 32'd1);
      chk("idle_hs", 32'(pwm_hs_o[0]), 32'd0);
      c0 = cyc; t_a = -1; t_b = -1;
      pwm_wfm_i[0] = 1'b1;
      repeat (20) begin
         tick();
         if (t_a < 0 && pwm_ls_o[0] == 1'b0) t_a = cyc;
         if (t_b < 0 && pwm_hs_o[0] == 1'b1) t_b = cyc;
      end
      chk("rise_lat", 32'(t_a - c0), 32'd2);
      chk("rise_gap", 32'(t_b - t_a), 32'd4);
      c0 = cyc; t_a = -1; t_b = -1;
      pwm_wfm_i[0] = 1'b0;
      repeat (20) begin
         tick();
         if (t_a < 0 && pwm_hs_o[0] == 1'b0) t_a = cyc;
         if (t_b < 0 && pwm_ls_o[0] == 1'b1) t_b = cyc;
      end
      chk("fall_lat", 32'(t_a - c0), 32'd2);
      chk("fall_gap", 32'(t_b - t_a), 32'd6);

      // glitch: 4-cycle pulse against dt_rise = 10
      reg_write(2'd1, 32'h0000_000A, 4'b0011);
      reg_write(2'd0, 32'h0400_0001, 4'hF);
      repeat (3) tick();
      seen = 1'b0;
      pwm_wfm_i[0] = 1'b1;
      repeat (4) begin tick(); seen |= pwm_hs_o[0]; end
      pwm_wfm_i[0] = 1'b0;
      repeat (15) begin tick(); seen |= pwm_hs_o[0]; end
      chk("glitch_hs", 32'(seen), 32'd0);
      chk("glitch_ls", 32'(pwm_ls_o[0]), 32'd1);
      reg_read(2'd2, d);
      chk("glitch_sts", d, 32'h0000_0100);
      chk("glitch_intr", 32'(dt_intr), 32'd1);
      reg_write(2'd2, 32'h0000_0100, 4'b0010);
      chk("glitch_clr_intr", 32'(dt_intr), 32'd0);
      reg_read(2'd2, d);
      chk("glitch_clr", d, 32'd0);

      // polarity
      reg_write(2'd0, 32'h0001_0100, 4'hF);
      tick();
      chk("pol_off_hs", 32'(pwm_hs_o[0]), 32'd1);
      chk("pol_off_ls", 32'(pwm_ls_o[0]), 32'd1);
      reg_write(2'd0, 32'h0001_0101, 4'hF);
      repeat (6) tick();
      chk("pol_on_hs", 32'(pwm_hs_o[0]), 32'd1);
      chk("pol_on_ls", 32'(pwm_ls_o[0]), 32'd0);

      // fault mid HS_ON
      reg_write(2'd1, 32'h0000_0503, 4'b0011);
      reg_write(2'd0, 32'h0300_0001, 4'hF);
      repeat (8) tick();
      pwm_wfm_i[0] = 1'b1;
      repeat (10) tick();
      chk("flt_pre_hs", 32'(pwm_hs_o[0]), 32'd1);
      c0 = cyc; t_a = -1;
      fault_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 1) fault_i = 1'b0;
         if (t_a < 0 && pwm_hs_o[0] == 1'b0 && pwm_ls_o[0] == 1'b0) t_a = cyc;
      end
      chk("flt_lat", 32'(t_a - c0), 32'd4);
      repeat (10) tick();
      chk("flt_hold_hs", 32'(pwm_hs_o[0]), 32'd0);
      chk("flt_hold_ls", 32'(pwm_ls_o[0]), 32'd0);
      chk("flt_intr", 32'(dt_intr), 32'd1);
      pwm_wfm_i[0] = 1'b0;
      reg_write(2'd2, 32'h0000_0001, 4'b0001);
      repeat (10) tick();
      chk("flt_restart_ls", 32'(pwm_ls_o[0]), 32'd1);
      reg_read(2'd2, d);
      chk("flt_sts_clr", d, 32'd0);

      // random stress
      for (int s = 0; s < 12; s++) begin
         logic [31:0] cv;
         reg_write(2'd2, 32'h0000_FFFF, 4'hF);
         reg_write(2'd1, {16'h0, 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))}, 4'b0011);
         cv = $urandom & CTRL_BITS;
         if (s % 2 == 0) cv[2:0] = 3'b111;
         reg_write(2'd0, cv, 4'($urandom_range(1, 15)));
         for (int k = 0; k < 150; k++) begin
            for (int c = 0; c < NCH; c++)
               if ($urandom_range(0, 5) == 0) pwm_wfm_i[c] = ~pwm_wfm_i[c];
            if (!fault_i && $urandom_range(0, 199) == 0) fault_i = 1'b1;
            else if (fault_i && $urandom_range(0, 2) == 0) fault_i = 1'b0;
            case ($urandom_range(0, 39))
               0: reg_write(2'd2, $urandom, 4'($urandom_range(0, 15)));
               1: reg_read(2'($urandom_range(0, 3)), d);
               2: reg_write(2'd0, $urandom & CTRL_BITS, 4'hF);
               3: reg_write(2'd1, $urandom, 4'($urandom_range(0, 15)));
               default: tick();
            endcase
         end
      end

      // asynchronous reset mid-operation
      fault_i = 1'b0;
      @(posedge mclk);
      #3 h_reset_n = 1'b0;
      #1;
      chk("mid_rst_hs", 32'(pwm_hs_o), 32'd0);
      chk("mid_rst_ls", 32'(pwm_ls_o), 32'd0);
      chk("mid_rst_ack", 32'(reg_ack), 32'd0);
      chk("mid_rst_intr", 32'(dt_intr), 32'd0);
      model_reset();
      reg_cs = 1'b0; reg_wr = 1'b0; reg_be = '0;
      #2 h_reset_n = 1'b1;
      reg_write(2'd0, 32'h0000_0700, 4'hF);
      tick();
      chk("rst_pol", 32'(pwm_hs_o), 32'h7);
      repeat (20) begin
         pwm_wfm_i = NCH'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
